// File: rtl/mem_stage_be_if.sv
// -----------------------------------------------------------------------------
// mem_stage_be_if
//  Bundles the EX/MEM -> MEM -> WB signals of the MIPS MEM stage.
//  master : EX/MEM side; drives control, address, store data and forwarding inputs,
//           and observes the registered MEM/WB outputs.
//  slave  : the MEM stage itself (mem_stage_be).
//  Signals
//   stall, flush                  pipeline hold / cancel
//   wbi, regaddr                  writeback control and destination register in
//   mem_we, mem_re                store / load request
//   mem_size, mem_unsigned        access size (00 b, 01 h, 1x w) and load extension
//   data, dataaddr                store data and byte address (ALU result)
//   forw, result_from_mem         store-data forwarding select and value from WB
//   wbo, regaddrout               registered writeback control / destination register
//   datafrommem, datafromimm      extended load data / registered ALU result
//   misaligned                    registered misalignment flag
// -----------------------------------------------------------------------------
interface mem_stage_be_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned WB_W      = 2,
    parameter int unsigned REGADDR_W = 5
);
    logic                 stall;
    logic                 flush;
    logic [WB_W-1:0]      wbi;
    logic [REGADDR_W-1:0] regaddr;
    logic                 mem_we;
    logic                 mem_re;
    logic [1:0]           mem_size;
    logic                 mem_unsigned;
    logic [DATA_W-1:0]    data;
    logic [31:0]          dataaddr;
    logic                 forw;
    logic [DATA_W-1:0]    result_from_mem;

    logic [WB_W-1:0]      wbo;
    logic [DATA_W-1:0]    datafrommem;
    logic [DATA_W-1:0]    datafromimm;
    logic [REGADDR_W-1:0] regaddrout;
    logic                 misaligned;

    modport master (
        output stall, flush, wbi, regaddr, mem_we, mem_re, mem_size, mem_unsigned,
        output data, dataaddr, forw, result_from_mem,
        input  wbo, datafrommem, datafromimm, regaddrout, misaligned
    );

    modport slave (
        input  stall, flush, wbi, regaddr, mem_we, mem_re, mem_size, mem_unsigned,
        input  data, dataaddr, forw, result_from_mem,
        output wbo, datafrommem, datafromimm, regaddrout, misaligned
    );
endinterface

// File: rtl/mem_stage_be.sv
// -----------------------------------------------------------------------------
// mem_stage_be
//  MIPS MEM pipeline stage with an internal byte-enabled data RAM. Handles
//  lb/lbu/lh/lhu/lw/sb/sh/sw, store-data forwarding, stall/flush and
//  misalignment detection, and registers the MEM/WB fields.
//  Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (RAM contents are not cleared)
//   bus    mem_stage_be_if.slave; see the interface header for the signal list
// -----------------------------------------------------------------------------
module mem_stage_be #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned WB_W      = 2,
    parameter int unsigned REGADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_be_if.slave  bus
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // ---------------------------------------------------------------- request
    logic [DATA_W-1:0] sd;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic              mis;
    logic              wr_en;
    logic [3:0]        byte_en;
    logic [31:0]       wr_data;

    always_comb begin
        sd       = bus.forw ? bus.result_from_mem : bus.data;
        word_idx = bus.dataaddr[ADDR_W-1:2];
        lane     = bus.dataaddr[1:0];

        // Reserved size 2'b11 behaves as a word access, including alignment.
        mis = (bus.mem_re | bus.mem_we) &
              (((bus.mem_size == SIZE_HALF) & lane[0]) |
               (bus.mem_size[1] & (lane != 2'b00)));

        wr_en = bus.mem_we & ~mis & ~bus.stall & ~bus.flush & reset;

        // Data is replicated across lanes so the byte enables alone pick the target.
        case (bus.mem_size)
            SIZE_BYTE: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{sd[7:0]}};
            end
            SIZE_HALF: begin
                byte_en = 4'b0011 << lane;
                wr_data = {2{sd[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = sd[31:0];
            end
        endcase
    end

    // -------------------------------------------------------------------- RAM
    logic [31:0] ram_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    ram_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------- MEM/WB registers
    logic [WB_W-1:0]      wbo_d,      wbo_q;
    logic [REGADDR_W-1:0] regaddr_d,  regaddr_q;
    logic [31:0]          imm_d,      imm_q;
    logic                 mis_d,      mis_q;
    logic [31:0]          rd_word_d,  rd_word_q;
    logic [1:0]           rd_off_d,   rd_off_q;
    logic [1:0]           rd_size_d,  rd_size_q;
    logic                 rd_uns_d,   rd_uns_q;

    always_comb begin
        wbo_d     = wbo_q;
        regaddr_d = regaddr_q;
        imm_d     = imm_q;
        mis_d     = mis_q;
        rd_word_d = rd_word_q;
        rd_off_d  = rd_off_q;
        rd_size_d = rd_size_q;
        rd_uns_d  = rd_uns_q;

        if (bus.flush) begin
            // Bubble: the read side is cleared too so datafrommem reads as zero.
            wbo_d     = '0;
            regaddr_d = '0;
            imm_d     = '0;
            mis_d     = 1'b0;
            rd_word_d = '0;
            rd_off_d  = '0;
            rd_size_d = '0;
            rd_uns_d  = 1'b0;
        end else if (!bus.stall) begin
            wbo_d     = mis ? '0 : bus.wbi;
            regaddr_d = bus.regaddr;
            imm_d     = bus.dataaddr;
            mis_d     = mis;
            // Sampled before the same-edge write lands, so reads are read-first.
            rd_word_d = ram_q[word_idx];
            rd_off_d  = lane;
            rd_size_d = bus.mem_size;
            rd_uns_d  = bus.mem_unsigned;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbo_q     <= '0;
            regaddr_q <= '0;
            imm_q     <= '0;
            mis_q     <= 1'b0;
            rd_word_q <= '0;
            rd_off_q  <= '0;
            rd_size_q <= '0;
            rd_uns_q  <= 1'b0;
        end else begin
            wbo_q     <= wbo_d;
            regaddr_q <= regaddr_d;
            imm_q     <= imm_d;
            mis_q     <= mis_d;
            rd_word_q <= rd_word_d;
            rd_off_q  <= rd_off_d;
            rd_size_q <= rd_size_d;
            rd_uns_q  <= rd_uns_d;
        end
    end

    // ------------------------------------------------------- load extraction
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        shifted = rd_word_q >> {rd_off_q, 3'b000};
        case (rd_size_q)
            SIZE_BYTE: load_val = rd_uns_q ? {24'd0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_val = rd_uns_q ? {16'd0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default:   load_val = rd_word_q;
        endcase
    end

    assign bus.wbo         = wbo_q;
    assign bus.regaddrout  = regaddr_q;
    assign bus.datafromimm = imm_q;
    assign bus.misaligned  = mis_q;
    assign bus.datafrommem = load_val;

endmodule

// File: tb/tb_mem_stage_be.sv
module tb_mem_stage_be;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned WB_W      = 2;
    localparam int unsigned REGADDR_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_be_if #(.DATA_W(DATA_W), .WB_W(WB_W), .REGADDR_W(REGADDR_W)) bus ();

    mem_stage_be #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .WB_W      (WB_W),
        .REGADDR_W (REGADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model: bytes of a 256-byte window; addresses used keep bits [14:8] zero,
    // while bits [31:15] are randomised to exercise address wrap.
    logic [7:0]  ref_mem [256];
    logic [1:0]  e_wbo;
    logic [4:0]  e_reg;
    logic [31:0] e_imm;
    logic        e_mis;
    logic [31:0] e_dfm;
    bit          e_dfm_ok;

    function automatic bit ref_mis(input bit we, input bit re, input logic [1:0] sz,
                                   input logic [31:0] a);
        int off = int'(a[1:0]);
        if (!(we || re)) return 1'b0;
        if (sz == 2'd1) return (off % 2) != 0;
        if (sz >= 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a);
        int base = int'(a[7:0]);
        int wbase = base - (base % 4);
        int v;
        if (sz == 2'd0) begin
            v = int'(ref_mem[base]);
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = int'(ref_mem[base]) + 256 * int'(ref_mem[base + 1]);
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            return {ref_mem[wbase + 3], ref_mem[wbase + 2], ref_mem[wbase + 1], ref_mem[wbase]};
        end
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] v);
        int base = int'(a[7:0]);
        int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        logic [31:0] t = v;
        for (int i = 0; i < n; i++) begin
            ref_mem[base + i] = t[7:0];
            t = t >> 8;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".wbo"}, 32'(bus.wbo), 32'(e_wbo));
        check_eq({tag, ".regaddrout"}, 32'(bus.regaddrout), 32'(e_reg));
        check_eq({tag, ".datafromimm"}, bus.datafromimm, e_imm);
        check_eq({tag, ".misaligned"}, 32'(bus.misaligned), 32'(e_mis));
        if (e_dfm_ok) check_eq({tag, ".datafrommem"}, bus.datafrommem, e_dfm);
    endtask

    task automatic issue(input string tag, input bit st, input bit fl, input bit we,
                         input bit re, input logic [1:0] sz, input bit un,
                         input logic [31:0] d, input logic [31:0] a, input bit fw,
                         input logic [31:0] rfm, input logic [1:0] wbi, input logic [4:0] ra);
        bit mis;
        bus.stall = st; bus.flush = fl; bus.mem_we = we; bus.mem_re = re;
        bus.mem_size = sz; bus.mem_unsigned = un; bus.data = d; bus.dataaddr = a;
        bus.forw = fw; bus.result_from_mem = rfm; bus.wbi = wbi; bus.regaddr = ra;
        @(posedge clk);
        mis = ref_mis(we, re, sz, a);
        if (fl) begin
            e_wbo = '0; e_reg = '0; e_imm = '0; e_mis = 1'b0; e_dfm = '0; e_dfm_ok = 1'b1;
        end else if (!st) begin
            if (re && !mis) begin
                e_dfm = ref_load(sz, un, a);
                e_dfm_ok = 1'b1;
            end else begin
                e_dfm_ok = 1'b0;
            end
            if (we && !mis) ref_store(sz, a, fw ? rfm : d);
            e_wbo = mis ? 2'd0 : wbi;
            e_reg = ra;
            e_imm = a;
            e_mis = mis;
        end
        #1;
        check_all(tag);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        issue("sw", 0, 0, 1, 0, 2'd2, 0, d, a, 0, 32'h0, 2'd1, 5'd0);
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input bit un,
                      input logic [31:0] a);
        issue(tag, 0, 0, 0, 1, sz, un, 32'h0, a, 0, 32'h0, 2'd3, 5'd9);
    endtask

    initial begin
        reset = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.mem_we = 0; bus.mem_re = 0; bus.mem_size = 0;
        bus.mem_unsigned = 0; bus.data = 0; bus.dataaddr = 0; bus.forw = 0;
        bus.result_from_mem = 0; bus.wbi = 0; bus.regaddr = 0;
        e_wbo = 0; e_reg = 0; e_imm = 0; e_mis = 0; e_dfm = 0; e_dfm_ok = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fill the model window so every later read is of known data.
        for (int i = 0; i < 64; i++) sw(32'(i * 4), $urandom);

        // 1: word store/load
        sw(32'h10, 32'h11223344);
        ld("t1_lw", 2'd2, 0, 32'h10);
        check_eq("t1_lw_val", bus.datafrommem, 32'h11223344);

        // 2: byte store into a known word, signed/unsigned byte loads, other lanes intact
        sw(32'h20, 32'h44332211);
        issue("sb", 0, 0, 1, 0, 2'd0, 0, 32'h000000AB, 32'h21, 0, 0, 2'd1, 5'd0);
        ld("t2_lb", 2'd0, 0, 32'h21);
        check_eq("t2_lb_val", bus.datafrommem, 32'hFFFFFFAB);
        ld("t2_lbu", 2'd0, 1, 32'h21);
        check_eq("t2_lbu_val", bus.datafrommem, 32'h000000AB);
        ld("t2_lw", 2'd2, 0, 32'h20);
        check_eq("t2_lanes", bus.datafrommem, 32'h4433AB11);

        // 3: halfword, then misaligned half load
        issue("sh", 0, 0, 1, 0, 2'd1, 0, 32'h00008001, 32'h32, 0, 0, 2'd1, 5'd0);
        ld("t3_lh", 2'd1, 0, 32'h32);
        check_eq("t3_lh_val", bus.datafrommem, 32'hFFFF8001);
        ld("t3_lhu", 2'd1, 1, 32'h32);
        check_eq("t3_lhu_val", bus.datafrommem, 32'h00008001);
        ld("t3_mis", 2'd1, 0, 32'h33);
        check_eq("t3_mis_flag", 32'(bus.misaligned), 32'd1);
        check_eq("t3_mis_wbo", 32'(bus.wbo), 32'd0);

        // 4: forwarded store data
        issue("sw_fw", 0, 0, 1, 0, 2'd2, 0, 32'h0, 32'h40, 1, 32'hDEADBEEF, 2'd1, 5'd0);
        ld("t4_lw", 2'd2, 0, 32'h40);
        check_eq("t4_val", bus.datafrommem, 32'hDEADBEEF);

        // 5: stall suppresses the store and holds outputs; flush makes a bubble
        sw(32'h44, 32'h00000077);
        ld("t5_pre", 2'd2, 0, 32'h40);
        issue("t5_stall", 1, 0, 1, 0, 2'd2, 0, 32'h5, 32'h44, 0, 0, 2'd2, 5'd4);
        check_eq("t5_hold_imm", bus.datafromimm, 32'h40);
        ld("t5_lw", 2'd2, 0, 32'h44);
        check_eq("t5_ram", bus.datafrommem, 32'h00000077);
        issue("t5_flush", 0, 1, 0, 1, 2'd2, 0, 32'h0, 32'h48, 0, 0, 2'd3, 5'd7);
        check_eq("t5_flush_wbo", 32'(bus.wbo), 32'd0);
        check_eq("t5_flush_reg", 32'(bus.regaddrout), 32'd0);

        // 6: asynchronous reset pulse between edges; RAM survives
        ld("t6_pre", 2'd2, 0, 32'h40);
        @(negedge clk);
        reset = 1'b0;
        #1;
        e_wbo = 0; e_reg = 0; e_imm = 0; e_mis = 0; e_dfm = 0; e_dfm_ok = 1'b1;
        check_all("t6_reset");
        #1;
        reset = 1'b1;
        ld("t6_lw", 2'd2, 0, 32'h10);
        check_eq("t6_ram", bus.datafrommem, 32'h11223344);

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r = $urandom;
            logic [31:0] a = {r[31:15], 7'd0, r[7:0]};
            if (r[8]) a[1:0] = 2'b00;
            issue("rand", ($urandom_range(7) == 0), ($urandom_range(9) == 0),
                  1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, a,
                  1'($urandom), $urandom, 2'($urandom), 5'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
